// File: rtl/bp_update_scheduler.sv
// Branch-outcome FIFO between ROB commit and the predictor's single BHT update port.
// Drains one entry per cycle and keeps saturating branch and mispredict counters.
module bp_update_scheduler #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rob_br_valid,
  input  logic [ADDR_WIDTH-1:0] rob_br_pc,
  input  logic                  rob_br_taken,
  input  logic                  rob_br_mispredict,
  output logic                  rob_br_ready,
  output logic                  bp_update_flag,
  output logic                  bp_jumped_flag,
  output logic [ADDR_WIDTH-1:0] bp_rob_pc,
  output logic [CNT_WIDTH-1:0]  stat_branch_cnt,
  output logic [CNT_WIDTH-1:0]  stat_mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_pc_mem [DEPTH];
  logic [DEPTH-1:0]      r_taken_mem;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W:0]        r_count;
  logic [CNT_WIDTH-1:0]  r_br_cnt;
  logic [CNT_WIDTH-1:0]  r_mis_cnt;

  logic w_push;
  logic w_pop;
  logic w_nonempty;

  assign w_nonempty     = (r_count != '0);
  // Ready ignores a same-cycle pop, so a full FIFO refuses even while draining.
  assign rob_br_ready   = rdy && (r_count < L_DEPTH);
  assign bp_update_flag = rdy && w_nonempty;
  assign w_push         = rob_br_valid && rob_br_ready;
  assign w_pop          = bp_update_flag;

  assign bp_rob_pc           = w_nonempty ? r_pc_mem[r_rd_ptr] : '0;
  assign bp_jumped_flag      = w_nonempty ? r_taken_mem[r_rd_ptr] : 1'b0;
  assign stat_branch_cnt     = r_br_cnt;
  assign stat_mispredict_cnt = r_mis_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= rob_br_pc;
      r_taken_mem[r_wr_ptr] <= rob_br_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (r_br_cnt != '1)
          r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
        if (rob_br_mispredict && (r_mis_cnt != '1))
          r_mis_cnt <= r_mis_cnt + CNT_WIDTH'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: per-cycle vector table plus
// hand-written reset-mid-operation and counter-saturation sequences.
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rob_br_valid;
  logic [31:0] rob_br_pc;
  logic        rob_br_taken;
  logic        rob_br_mispredict;
  logic        rob_br_ready;
  logic        bp_update_flag;
  logic        bp_jumped_flag;
  logic [31:0] bp_rob_pc;
  logic [3:0]  stat_branch_cnt;
  logic [3:0]  stat_mispredict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_update_scheduler #(
    .DEPTH(4),
    .ADDR_WIDTH(32),
    .CNT_WIDTH(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .rob_br_valid       (rob_br_valid),
    .rob_br_pc          (rob_br_pc),
    .rob_br_taken       (rob_br_taken),
    .rob_br_mispredict  (rob_br_mispredict),
    .rob_br_ready       (rob_br_ready),
    .bp_update_flag     (bp_update_flag),
    .bp_jumped_flag     (bp_jumped_flag),
    .bp_rob_pc          (bp_rob_pc),
    .stat_branch_cnt    (stat_branch_cnt),
    .stat_mispredict_cnt(stat_mispredict_cnt)
  );

  // One record per cycle: inputs applied in that cycle, outputs expected in that same cycle.
  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic        m;
    logic        e_ready;
    logic        e_flag;
    logic        e_j;
    logic [31:0] e_pc;
    logic [3:0]  e_b;
    logic [3:0]  e_m;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                              input logic t, input logic m, input logic er,
                              input logic ef, input logic ej, input logic [31:0] ep,
                              input logic [3:0] eb, input logic [3:0] em);
    vec_t x;
    x.rdy = r; x.v = v; x.pc = pc; x.t = t; x.m = m;
    x.e_ready = er; x.e_flag = ef; x.e_j = ej; x.e_pc = ep; x.e_b = eb; x.e_m = em;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic t, input logic m);
    rdy = r; rob_br_valid = v; rob_br_pc = pc; rob_br_taken = t; rob_br_mispredict = m;
  endtask

  initial begin
    //            rdy v  pc         t  m   rdy flg j  pc         b  m
    vecs[0]  = mk(0, 0, 32'h0,    0, 0,   0, 0, 0, 32'h0,    0, 0);
    vecs[1]  = mk(1, 0, 32'h0,    0, 0,   1, 0, 0, 32'h0,    0, 0);
    vecs[2]  = mk(1, 1, 32'h1000, 1, 1,   1, 0, 0, 32'h0,    0, 0);
    vecs[3]  = mk(1, 0, 32'h0,    0, 0,   1, 1, 1, 32'h1000, 1, 1);
    vecs[4]  = mk(1, 0, 32'h0,    0, 0,   1, 0, 0, 32'h0,    1, 1);
    vecs[5]  = mk(1, 1, 32'h10,   0, 0,   1, 0, 0, 32'h0,    1, 1);
    vecs[6]  = mk(1, 1, 32'h14,   1, 1,   1, 1, 0, 32'h10,   2, 1);
    vecs[7]  = mk(1, 1, 32'h18,   0, 0,   1, 1, 1, 32'h14,   3, 2);
    vecs[8]  = mk(1, 1, 32'h1C,   1, 0,   1, 1, 0, 32'h18,   4, 2);
    vecs[9]  = mk(1, 0, 32'h0,    0, 0,   1, 1, 1, 32'h1C,   5, 2);
    vecs[10] = mk(1, 0, 32'h0,    0, 0,   1, 0, 0, 32'h0,    5, 2);
    vecs[11] = mk(1, 1, 32'h20,   1, 1,   1, 0, 0, 32'h0,    5, 2);
    vecs[12] = mk(0, 0, 32'h0,    0, 0,   0, 0, 1, 32'h20,   6, 3);
    vecs[13] = mk(0, 1, 32'h24,   0, 0,   0, 0, 1, 32'h20,   6, 3);
    vecs[14] = mk(0, 1, 32'h24,   0, 0,   0, 0, 1, 32'h20,   6, 3);
    vecs[15] = mk(1, 1, 32'h24,   0, 0,   1, 1, 1, 32'h20,   6, 3);
    vecs[16] = mk(1, 0, 32'h0,    0, 0,   1, 1, 0, 32'h24,   7, 3);
    vecs[17] = mk(1, 0, 32'h0,    0, 0,   1, 0, 0, 32'h0,    7, 3);

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].rdy, vecs[i].v, vecs[i].pc, vecs[i].t, vecs[i].m);
      #1;
      chk($sformatf("row%0d ready", i), 32'(rob_br_ready),        32'(vecs[i].e_ready));
      chk($sformatf("row%0d flag", i),  32'(bp_update_flag),      32'(vecs[i].e_flag));
      chk($sformatf("row%0d jumped", i),32'(bp_jumped_flag),      32'(vecs[i].e_j));
      chk($sformatf("row%0d pc", i),    bp_rob_pc,                vecs[i].e_pc);
      chk($sformatf("row%0d brcnt", i), 32'(stat_branch_cnt),     32'(vecs[i].e_b));
      chk($sformatf("row%0d miscnt", i),32'(stat_mispredict_cnt), 32'(vecs[i].e_m));
    end

    // Reset with an entry queued: the entry is discarded and the blocked push is not taken.
    @(posedge clk);
    #1 drive(1, 1, 32'h40, 1, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 1, 32'h44, 0, 1);
    #1 chk("pre_rst flag", 32'(bp_update_flag), 32'd1);
    chk("pre_rst pc", bp_rob_pc, 32'h40);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 32'h0, 0, 0);
    #1 chk("post_rst ready", 32'(rob_br_ready), 32'd1);
    chk("post_rst flag", 32'(bp_update_flag), 32'd0);
    chk("post_rst pc", bp_rob_pc, 32'h0);
    chk("post_rst brcnt", 32'(stat_branch_cnt), 32'd0);
    chk("post_rst miscnt", 32'(stat_mispredict_cnt), 32'd0);
    @(posedge clk);
    #2 chk("post_rst idle flag", 32'(bp_update_flag), 32'd0);

    // Stream 20 mispredicted branches back to back; counters stop at 15.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 drive(1, 1, 32'h100 + 32'(4 * i), 1'(i % 2), 1);
      #1;
      if (i > 0) begin
        chk($sformatf("sat%0d flag", i), 32'(bp_update_flag), 32'd1);
        chk($sformatf("sat%0d pc", i), bp_rob_pc, 32'h100 + 32'(4 * (i - 1)));
        chk($sformatf("sat%0d jumped", i), 32'(bp_jumped_flag), 32'((i - 1) % 2));
      end
      if (i == 15 || i == 16)
        chk($sformatf("sat%0d brcnt", i), 32'(stat_branch_cnt), 32'd15);
    end
    @(posedge clk);
    #1 drive(1, 0, 32'h0, 0, 0);
    #1 chk("sat tail flag", 32'(bp_update_flag), 32'd1);
    chk("sat tail pc", bp_rob_pc, 32'h14C);
    @(posedge clk);
    #2 chk("sat empty flag", 32'(bp_update_flag), 32'd0);
    chk("sat brcnt", 32'(stat_branch_cnt), 32'd15);
    chk("sat miscnt", 32'(stat_mispredict_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
